// File: rtl/pipeline_stage_sequencer.sv
// Single-clock enable sequencer for the five MIPS pipeline stages: fill/drain, load-use stalls,
// and interrupt entry/return (compiled in only when SEQ_IRQ_EN is defined).
module pipeline_stage_sequencer #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter logic [7:0]  IRQ_VECTOR        = 8'hF0,
    parameter logic [4:0]  OP_RETI           = 5'b11111
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Run,
    input  logic [19:0] Ins,
    input  logic        Load_ex,
    input  logic [4:0]  Rw_ex,
    input  logic [7:0]  Current_address,
    input  logic        Interrupt,
    output logic [4:0]  En_stage,
    output logic        Flush_id,
    output logic        Pc_load,
    output logic [7:0]  Pc_target,
    output logic [7:0]  Epc,
    output logic        Irq_ack,
    output logic [2:0]  State
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFill  = 3'd1,
        StRun   = 3'd2,
        StStall = 3'd3,
        StIrq   = 3'd4,
        StDrain = 3'd5
    } state_t;

    localparam logic [1:0] StallInit = 2'(LOAD_STALL_CYCLES - 1);

    state_t     state_q, state_d;
    logic [4:0] en_q, en_d;
    logic       flush_q, flush_d;
    logic [1:0] cnt_q, cnt_d;
    logic       hazard;
    logic       irq_req, reti_req;
    logic       take_irq, do_reti, drain_entry;
    logic       unused_ins;

    assign hazard = Load_ex && (Rw_ex != 5'd0) && ((Ins[9:5] == Rw_ex) || (Ins[4:0] == Rw_ex));
    assign unused_ins = ^Ins[14:10];

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        flush_d     = 1'b0;
        cnt_d       = cnt_q;
        take_irq    = 1'b0;
        do_reti     = 1'b0;
        drain_entry = 1'b0;
        case (state_q)
            StIdle: begin
                if (Run) begin
                    state_d = StFill;
                    en_d    = 5'b00001;
                end
            end
            StFill: begin
                en_d = {en_q[3:0], 1'b1};
                if (en_d == 5'b11111) state_d = StRun;
            end
            StRun: begin
                en_d = 5'b11111;
                if (!Run) begin
                    state_d     = StDrain;
                    en_d        = 5'b11110;
                    drain_entry = 1'b1;
                end else if (hazard) begin
                    state_d = StStall;
                    en_d    = 5'b11100;
                    flush_d = 1'b1;
                    cnt_d   = StallInit;
                end else if (irq_req) begin
                    state_d  = StIrq;
                    flush_d  = 1'b1;
                    take_irq = 1'b1;
                end else if (reti_req) begin
                    flush_d = 1'b1;
                    do_reti = 1'b1;
                end
            end
            StStall: begin
                if (cnt_q == 2'd0) begin
                    state_d = StRun;
                    en_d    = 5'b11111;
                end else begin
                    cnt_d   = cnt_q - 2'd1;
                    flush_d = 1'b1;
                end
            end
            StIrq: begin
                state_d = StRun;
            end
            StDrain: begin
                en_d = {en_q[3:0], 1'b0};
                if (en_d == 5'b00000) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                en_d    = 5'b00000;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= StIdle;
            en_q    <= 5'b00000;
            flush_q <= 1'b0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SEQ_IRQ_EN
    logic       sync1_q, sync2_q, sync3_q;
    logic       pending_q, pending_d;
    logic       mask_q, mask_d;
    logic       irq_edge;
    logic [7:0] epc_q, pc_target_q;
    logic       pc_load_q, irq_ack_q;

    assign irq_edge = sync2_q & ~sync3_q;
    // A fresh edge may be taken in the same cycle it is detected, before it reaches pending.
    assign irq_req  = (pending_q | irq_edge) & ~mask_q;
    assign reti_req = (Ins[19:15] == OP_RETI) & mask_q;

    always_comb begin
        pending_d = (pending_q | (irq_edge & ~mask_q)) & ~take_irq & ~drain_entry;
        mask_d    = mask_q;
        if (take_irq) mask_d = 1'b1;
        else if (do_reti) mask_d = 1'b0;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            pending_q   <= 1'b0;
            mask_q      <= 1'b0;
            epc_q       <= 8'h00;
            pc_target_q <= 8'h00;
            pc_load_q   <= 1'b0;
            irq_ack_q   <= 1'b0;
        end else begin
            sync1_q     <= Interrupt;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            if (take_irq) epc_q <= Current_address;
            pc_target_q <= take_irq ? IRQ_VECTOR : (do_reti ? epc_q : 8'h00);
            pc_load_q   <= take_irq | do_reti;
            irq_ack_q   <= take_irq;
        end
    end

    assign Epc       = epc_q;
    assign Pc_target = pc_target_q;
    assign Pc_load   = pc_load_q;
    assign Irq_ack   = irq_ack_q;
`else
    logic unused_irq;

    assign irq_req    = 1'b0;
    assign reti_req   = 1'b0;
    assign unused_irq = ^{Interrupt, Current_address, Ins[19:15], take_irq, do_reti, drain_entry};
    assign Epc        = 8'h00;
    assign Pc_target  = 8'h00;
    assign Pc_load    = 1'b0;
    assign Irq_ack    = 1'b0;
`endif

    assign En_stage = en_q;
    assign Flush_id = flush_q;
    assign State    = state_q;

endmodule

// File: tb/tb_pipeline_stage_sequencer.sv
// Directed bench for pipeline_stage_sequencer; interrupt expectations follow SEQ_IRQ_EN.
module tb_pipeline_stage_sequencer;

    logic        Clk;
    logic        Rst_n;
    logic        Run;
    logic [19:0] Ins;
    logic        Load_ex;
    logic [4:0]  Rw_ex;
    logic [7:0]  Current_address;
    logic        Interrupt;
    logic [4:0]  En_stage;
    logic        Flush_id;
    logic        Pc_load;
    logic [7:0]  Pc_target;
    logic [7:0]  Epc;
    logic        Irq_ack;
    logic [2:0]  State;

    int total = 0;
    int bad   = 0;

    localparam logic [19:0] InsHaz  = 20'h00060; // Ins[9:5] = 3
    localparam logic [19:0] InsReti = 20'hF8000; // opcode 11111

    pipeline_stage_sequencer #(
        .LOAD_STALL_CYCLES(2),
        .IRQ_VECTOR       (8'hF0),
        .OP_RETI          (5'b11111)
    ) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .Run            (Run),
        .Ins            (Ins),
        .Load_ex        (Load_ex),
        .Rw_ex          (Rw_ex),
        .Current_address(Current_address),
        .Interrupt      (Interrupt),
        .En_stage       (En_stage),
        .Flush_id       (Flush_id),
        .Pc_load        (Pc_load),
        .Pc_target      (Pc_target),
        .Epc            (Epc),
        .Irq_ack        (Irq_ack),
        .State          (State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".en"}, 32'(En_stage), 32'h0);
        check({tag, ".flush"}, 32'(Flush_id), 32'h0);
        check({tag, ".pcl"}, 32'(Pc_load), 32'h0);
        check({tag, ".pct"}, 32'(Pc_target), 32'h0);
        check({tag, ".epc"}, 32'(Epc), 32'h0);
        check({tag, ".ack"}, 32'(Irq_ack), 32'h0);
        check({tag, ".state"}, 32'(State), 32'h0);
    endtask

    task automatic check_es(input string tag, input logic [4:0] en, input logic [2:0] st);
        check({tag, ".en"}, 32'(En_stage), 32'(en));
        check({tag, ".state"}, 32'(State), 32'(st));
    endtask

    initial begin
        logic [4:0] fill_seq [5];
        fill_seq = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};

        Rst_n = 1'b0;
        Run = 1'b0;
        Ins = 20'h0;
        Load_ex = 1'b0;
        Rw_ex = 5'd0;
        Current_address = 8'h00;
        Interrupt = 1'b0;
        #1;
        check_reset("reset");
        tick();
        tick();
        Rst_n = 1'b1;
        tick();
        check_es("idle", 5'b00000, 3'd0);

        // Fill
        Run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("fill%0d.en", i), 32'(En_stage), 32'(fill_seq[i]));
            check($sformatf("fill%0d.state", i), 32'(State), (i == 4) ? 32'd2 : 32'd1);
        end

        // Load-use stall, two bubbles
        Load_ex = 1'b1;
        Rw_ex = 5'd3;
        Ins = InsHaz;
        tick();
        check_es("stall0", 5'b11100, 3'd3);
        check("stall0.flush", 32'(Flush_id), 32'h1);
        Load_ex = 1'b0;
        tick();
        check_es("stall1", 5'b11100, 3'd3);
        check("stall1.flush", 32'(Flush_id), 32'h1);
        tick();
        check_es("stall_end", 5'b11111, 3'd2);
        check("stall_end.flush", 32'(Flush_id), 32'h0);

        // Rw_ex = 0 is never a hazard
        Load_ex = 1'b1;
        Rw_ex = 5'd0;
        Ins = 20'h0;
        tick();
        check_es("nohaz", 5'b11111, 3'd2);
        check("nohaz.flush", 32'(Flush_id), 32'h0);
        Load_ex = 1'b0;

`ifdef SEQ_IRQ_EN
        Current_address = 8'h2A;
        Interrupt = 1'b1;
        tick();
        check("irq_e1.ack", 32'(Irq_ack), 32'h0);
        tick();
        check("irq_e2.ack", 32'(Irq_ack), 32'h0);
        tick();
        check("irq.ack", 32'(Irq_ack), 32'h1);
        check("irq.pcl", 32'(Pc_load), 32'h1);
        check("irq.pct", 32'(Pc_target), 32'hF0);
        check("irq.flush", 32'(Flush_id), 32'h1);
        check("irq.state", 32'(State), 32'd4);
        check("irq.epc", 32'(Epc), 32'h2A);
        Interrupt = 1'b0;
        tick();
        check("irq_after.ack", 32'(Irq_ack), 32'h0);
        check("irq_after.pcl", 32'(Pc_load), 32'h0);
        check("irq_after.flush", 32'(Flush_id), 32'h0);
        check("irq_after.state", 32'(State), 32'd2);
        check("irq_after.epc", 32'(Epc), 32'h2A);
        tick();
        tick();
        // Second edge while masked is dropped
        Interrupt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("masked%0d.ack", i), 32'(Irq_ack), 32'h0);
            check($sformatf("masked%0d.state", i), 32'(State), 32'd2);
        end
        Ins = InsReti;
        tick();
        check("reti.pcl", 32'(Pc_load), 32'h1);
        check("reti.pct", 32'(Pc_target), 32'h2A);
        check("reti.flush", 32'(Flush_id), 32'h1);
        check("reti.state", 32'(State), 32'd2);
        tick();
        check("reti_unmasked.pcl", 32'(Pc_load), 32'h0);
        check("reti_unmasked.flush", 32'(Flush_id), 32'h0);
        Ins = 20'h0;
        Interrupt = 1'b0;
        tick();
        tick();
        tick();

        // Edge detected in the same cycle as a hazard: stall first, then IRQ
        Interrupt = 1'b1;
        tick();
        tick();
        Load_ex = 1'b1;
        Rw_ex = 5'd3;
        Ins = InsHaz;
        tick();
        check_es("hirq_stall0", 5'b11100, 3'd3);
        check("hirq_stall0.ack", 32'(Irq_ack), 32'h0);
        Load_ex = 1'b0;
        Ins = 20'h0;
        Current_address = 8'h31;
        tick();
        check_es("hirq_stall1", 5'b11100, 3'd3);
        tick();
        check_es("hirq_run", 5'b11111, 3'd2);
        check("hirq_run.ack", 32'(Irq_ack), 32'h0);
        tick();
        check("hirq.ack", 32'(Irq_ack), 32'h1);
        check("hirq.state", 32'(State), 32'd4);
        check("hirq.epc", 32'(Epc), 32'h31);
        tick();
        Ins = InsReti;
        tick();
        check("hirq_reti.pcl", 32'(Pc_load), 32'h1);
        check("hirq_reti.pct", 32'(Pc_target), 32'h31);
        Ins = 20'h0;
        Interrupt = 1'b0;
        tick();
`else
        Current_address = 8'h2A;
        Interrupt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("noirq%0d.ack", i), 32'(Irq_ack), 32'h0);
            check($sformatf("noirq%0d.pcl", i), 32'(Pc_load), 32'h0);
            check($sformatf("noirq%0d.state", i), 32'(State), 32'd2);
        end
        Ins = InsReti;
        tick();
        check("noirq_reti.pcl", 32'(Pc_load), 32'h0);
        check("noirq_reti.flush", 32'(Flush_id), 32'h0);
        check("noirq_reti.epc", 32'(Epc), 32'h0);
        Ins = 20'h0;
        Interrupt = 1'b0;
        tick();
`endif

        // Drain, with Run re-asserted mid-drain
        Run = 1'b0;
        tick();
        check_es("drain0", 5'b11110, 3'd5);
        tick();
        check_es("drain1", 5'b11100, 3'd5);
        tick();
        check_es("drain2", 5'b11000, 3'd5);
        Run = 1'b1;
        tick();
        check_es("drain3", 5'b10000, 3'd5);
        tick();
        check_es("drain4", 5'b00000, 3'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("refill%0d.en", i), 32'(En_stage), 32'(fill_seq[i]));
        end
        check("refill.state", 32'(State), 32'd2);

        // Asynchronous reset in the middle of a stall
        Load_ex = 1'b1;
        Rw_ex = 5'd3;
        Ins = InsHaz;
        tick();
        check_es("pre_rst", 5'b11100, 3'd3);
        #2;
        Rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        Load_ex = 1'b0;
        Ins = 20'h0;
        Run = 1'b0;
        tick();
        Rst_n = 1'b1;
        tick();
        check_es("post_rst", 5'b00000, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
